// File: rtl/sr_pkg.sv
// Shared types and constants for the SR latch command driver.
package sr_pkg;

  // Driver sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2
  } sr_state_e;

  // Latch input codes as {S, R}. Bit 1 is S, bit 0 is R; 2'b11 is never produced.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;

  // Larger of two integers, used to size the shared interval counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_latch_driver.sv
// Command-side initiator for a clocked SR latch: each accepted set/clear command
// becomes a timed S or R pulse, a guard interval with S=R=0, then a Q readback check.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int GUARD_CYCLES   = 1,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  output logic       cmd_ready,
  input  logic       q_fb,
  output logic       s_out,
  output logic       r_out,
  output logic       done,
  output logic       err,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(max_int(PULSE_CYCLES, GUARD_CYCLES) + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);

  sr_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cmd_q, cmd_n;
  logic [1:0]    sr_q, sr_n;
  logic          done_n, err_n;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE outside reset; there is no command buffer, so a
  // source presenting a command while the driver is busy must hold it until accepted.
  assign cmd_ready = (state == IDLE) && !reset;

  // S and R come straight from one registered code, so they can never both be high.
  assign s_out     = sr_q[1];
  assign r_out     = sr_q[0];
  assign state_dbg = state;

  // State, counter, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cmd_q <= 1'b0;
      sr_q  <= SR_HOLD;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cmd_q <= cmd_n;
      sr_q  <= sr_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // Next-state, counter and output decode; the counter is reloaded on each state entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = cmd_q;
    sr_n    = SR_HOLD;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_n = cmd_set;
          if (SKIP_REDUNDANT && (q_fb == cmd_set)) begin
            // Latch already holds the requested value: finish without a pulse.
            done_n = 1'b1;
          end else begin
            state_n = PULSE;
            cnt_n   = PULSE_LOAD;
            sr_n    = cmd_set ? SR_SET : SR_CLR;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = GUARD;
          cnt_n   = GUARD_LOAD;
        end else begin
          cnt_n = cnt - CW'(1);
          sr_n  = cmd_q ? SR_SET : SR_CLR;
        end
      end
      GUARD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = (q_fb != cmd_q);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: one instance with 2/1 timing, one with 3/2.
module tb_sr_latch_driver;

  logic       clk;
  logic       reset;

  // Instance A: PULSE_CYCLES=2, GUARD_CYCLES=1
  logic       cmd_valid, cmd_set, q_fb;
  logic       cmd_ready, s_out, r_out, done, err;
  logic [1:0] state_dbg;

  // Instance B: PULSE_CYCLES=3, GUARD_CYCLES=2
  logic       cmd_valid2, cmd_set2, q_fb2;
  logic       cmd_ready2, s_out2, r_out2, done2, err2;
  logic [1:0] state_dbg2;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  sr_latch_driver #(.PULSE_CYCLES(2), .GUARD_CYCLES(1), .SKIP_REDUNDANT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
    .cmd_ready(cmd_ready), .q_fb(q_fb), .s_out(s_out), .r_out(r_out),
    .done(done), .err(err), .state_dbg(state_dbg)
  );

  sr_latch_driver #(.PULSE_CYCLES(3), .GUARD_CYCLES(2), .SKIP_REDUNDANT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_set(cmd_set2),
    .cmd_ready(cmd_ready2), .q_fb(q_fb2), .s_out(s_out2), .r_out(r_out2),
    .done(done2), .err(err2), .state_dbg(state_dbg2)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forbidden-code monitor on both instances, sampled on the falling edge.
  always @(negedge clk) begin
    check("a_no_s_and_r", {31'd0, s_out & r_out}, 32'd0);
    check("b_no_s_and_r", {31'd0, s_out2 & r_out2}, 32'd0);
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_set = 1'b0; q_fb = 1'b0;
    cmd_valid2 = 1'b0; cmd_set2 = 1'b0; q_fb2 = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_s", {31'd0, s_out}, 32'd0);
    check("rst_r", {31'd0, r_out}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    reset = 1'b0;
    #1;
    check("rst_ready_rel", {31'd0, cmd_ready}, 32'd1);
    check("rst_ready2_rel", {31'd0, cmd_ready2}, 32'd1);

    // 1: set from Q=0
    cmd_valid = 1'b1; cmd_set = 1'b1; q_fb = 1'b0;
    tick(); // E0
    cmd_valid = 1'b0;
    check("t1_e0_s", {31'd0, s_out}, 32'd1);
    check("t1_e0_r", {31'd0, r_out}, 32'd0);
    check("t1_e0_ready", {31'd0, cmd_ready}, 32'd0);
    check("t1_e0_state", {30'd0, state_dbg}, {30'd0, ST_PULSE});
    tick(); // E1
    check("t1_e1_s", {31'd0, s_out}, 32'd1);
    check("t1_e1_done", {31'd0, done}, 32'd0);
    tick(); // E2
    q_fb = 1'b1;
    check("t1_e2_s", {31'd0, s_out}, 32'd0);
    check("t1_e2_r", {31'd0, r_out}, 32'd0);
    check("t1_e2_state", {30'd0, state_dbg}, {30'd0, ST_GUARD});
    check("t1_e2_done", {31'd0, done}, 32'd0);
    tick(); // E3
    check("t1_e3_done", {31'd0, done}, 32'd1);
    check("t1_e3_err", {31'd0, err}, 32'd0);
    check("t1_e3_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    check("t1_after_done", {31'd0, done}, 32'd0);

    // 2: clear with latch stuck at 1
    q_fb = 1'b1; cmd_valid = 1'b1; cmd_set = 1'b0;
    tick(); // E0
    cmd_valid = 1'b0;
    check("t2_e0_r", {31'd0, r_out}, 32'd1);
    check("t2_e0_s", {31'd0, s_out}, 32'd0);
    tick(); // E1
    check("t2_e1_r", {31'd0, r_out}, 32'd1);
    tick(); // E2
    check("t2_e2_r", {31'd0, r_out}, 32'd0);
    tick(); // E3
    check("t2_e3_done", {31'd0, done}, 32'd1);
    check("t2_e3_err", {31'd0, err}, 32'd1);
    tick();
    check("t2_err_clear", {31'd0, err}, 32'd0);

    // 3: redundant set, Q already 1
    q_fb = 1'b1; cmd_valid = 1'b1; cmd_set = 1'b1;
    tick(); // E0
    cmd_valid = 1'b0;
    check("t3_e0_done", {31'd0, done}, 32'd1);
    check("t3_e0_err", {31'd0, err}, 32'd0);
    check("t3_e0_s", {31'd0, s_out}, 32'd0);
    check("t3_e0_ready", {31'd0, cmd_ready}, 32'd1);
    check("t3_e0_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    tick();
    check("t3_e1_done", {31'd0, done}, 32'd0);
    check("t3_e1_s", {31'd0, s_out}, 32'd0);

    // 4: back-to-back set then clear, valid held high
    q_fb = 1'b0; cmd_valid = 1'b1; cmd_set = 1'b1;
    tick(); // E0
    check("t4_e0_s", {31'd0, s_out}, 32'd1);
    tick(); // E1
    tick(); // E2
    cmd_set = 1'b0; q_fb = 1'b1;
    check("t4_e2_s", {31'd0, s_out}, 32'd0);
    tick(); // E3: first command completes, second is presented during the done cycle
    check("t4_e3_done", {31'd0, done}, 32'd1);
    check("t4_e3_err", {31'd0, err}, 32'd0);
    check("t4_e3_ready", {31'd0, cmd_ready}, 32'd1);
    check("t4_e3_r", {31'd0, r_out}, 32'd0);
    tick(); // E4: second command accepted at the end of the done cycle
    cmd_valid = 1'b0;
    check("t4_e4_r", {31'd0, r_out}, 32'd1);
    check("t4_e4_s", {31'd0, s_out}, 32'd0);
    check("t4_e4_done", {31'd0, done}, 32'd0);
    tick(); // E5
    check("t4_e5_r", {31'd0, r_out}, 32'd1);
    tick(); // E6
    q_fb = 1'b0;
    check("t4_e6_r", {31'd0, r_out}, 32'd0);
    tick(); // E7
    check("t4_e7_done", {31'd0, done}, 32'd1);
    check("t4_e7_err", {31'd0, err}, 32'd0);
    tick();

    // 5: reset during PULSE
    q_fb = 1'b0; cmd_valid = 1'b1; cmd_set = 1'b1;
    tick(); // E0
    cmd_valid = 1'b0;
    reset = 1'b1;
    check("t5_e0_s", {31'd0, s_out}, 32'd1);
    check("t5_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    tick(); // E1 with reset high
    check("t5_e1_s", {31'd0, s_out}, 32'd0);
    check("t5_e1_r", {31'd0, r_out}, 32'd0);
    check("t5_e1_ready", {31'd0, cmd_ready}, 32'd0);
    check("t5_e1_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    tick();
    check("t5_e2_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_ready_rel", {31'd0, cmd_ready}, 32'd1);
      check("t5_no_done", {31'd0, done}, 32'd0);
      check("t5_s_low", {31'd0, s_out}, 32'd0);
    end

    // 6: 3/2 instance, cmd_valid/cmd_set toggled while busy
    q_fb2 = 1'b0; cmd_valid2 = 1'b1; cmd_set2 = 1'b1;
    tick(); // E0
    check("t6_e0_s", {31'd0, s_out2}, 32'd1);
    begin
      logic [5:0] exp_s;
      logic [5:0] exp_done;
      logic [5:0] exp_ready;
      logic [5:0] vld_pat;
      exp_s     = 6'b000110; // bits 1..5 = after E1..E5
      exp_done  = 6'b100000;
      exp_ready = 6'b100000;
      vld_pat   = 6'b001010; // valid driven before E1..E5 (bit k = before Ek)
      for (int k = 1; k <= 5; k++) begin
        cmd_valid2 = vld_pat[k];
        cmd_set2   = ~cmd_set2;
        if (k == 4) q_fb2 = 1'b1;
        if (k == 5) cmd_valid2 = 1'b0;
        tick();
        check($sformatf("t6_e%0d_s", k), {31'd0, s_out2}, {31'd0, exp_s[k]});
        check($sformatf("t6_e%0d_r", k), {31'd0, r_out2}, 32'd0);
        check($sformatf("t6_e%0d_done", k), {31'd0, done2}, {31'd0, exp_done[k]});
        check($sformatf("t6_e%0d_ready", k), {31'd0, cmd_ready2}, {31'd0, exp_ready[k]});
      end
      check("t6_e5_err", {31'd0, err2}, 32'd0);
    end
    tick();
    check("t6_e6_done", {31'd0, done2}, 32'd0);
    check("t6_e6_state", {30'd0, state_dbg2}, {30'd0, ST_IDLE});

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
